// File: rtl/risc_v_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package risc_v_pkg;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } boot_state_t;

  // A word count larger than the memory capacity cannot be loaded.
  function automatic logic len_overflow(input logic [8*LEN_BYTES-1:0] n,
                                        input int unsigned addr_w);
    return {1'b0, n} > ((8 * LEN_BYTES + 1)'(1) << addr_w);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words; flags the cycle the last lane arrives.
module byte_packer
  import risc_v_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_word_valid,
  output logic [8*WORD_BYTES-1:0] o_word
);

  logic [LANE_W-1:0]           r_lane;
  logic [8*(WORD_BYTES-1)-1:0] r_sr;
  logic                        w_last_lane;

  assign w_last_lane = (r_lane == LANE_W'(WORD_BYTES - 1));

  // Newest byte enters at the top so the first byte ends up in the low lane.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_lane <= '0;
      r_sr   <= '0;
    end else if (i_valid) begin
      r_lane <= r_lane + LANE_W'(1);
      r_sr   <= {i_byte, r_sr[8*(WORD_BYTES-1)-1:8]};
    end
  end

  assign o_word_valid = i_valid && w_last_lane;
  assign o_word       = {i_byte, r_sr};

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory,
// then releases the core from reset.
module imem_boot_loader
  import risc_v_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  boot_state_t       r_state;
  boot_state_t       w_state_next;
  logic [15:0]       r_len;
  logic [7:0]        r_xor;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_acc;
  logic              w_pack_valid;
  logic              w_pack_clr;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [15:0]       w_len_full;
  logic              w_last_word;
  logic              w_enter_term;

  assign w_acc        = in_valid && in_ready;
  assign w_pack_valid = w_acc && (r_state == S_DATA);
  assign w_pack_clr   = (r_state != S_DATA);
  assign w_len_full   = {in_data, r_len[7:0]};
  assign w_last_word  = (16'(r_idx) == r_len - 16'd1);
  assign w_enter_term = (w_state_next == S_DONE) || (w_state_next == S_ERR);

  byte_packer u_packer (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr        (w_pack_clr),
    .i_valid      (w_pack_valid),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_LEN0: if (w_acc) w_state_next = S_LEN1;
      S_LEN1: begin
        if (w_acc) begin
          if (len_overflow(w_len_full, ADDR_W)) begin
            w_state_next = S_ERR;
          end else if (w_len_full == 16'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: if (w_word_valid && w_last_word) w_state_next = S_CSUM;
      S_CSUM: if (w_acc) w_state_next = (in_data == r_xor) ? S_DONE : S_ERR;
      S_DONE, S_ERR: w_state_next = r_state;
      default: w_state_next = S_ERR;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (r_state)
      S_LEN0, S_LEN1, S_DATA, S_CSUM: in_ready = !rst;
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
    core_rst_n = done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len   <= '0;
      r_xor   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_word_valid;
      if (w_acc && (r_state == S_LEN0)) r_len[7:0]  <= in_data;
      if (w_acc && (r_state == S_LEN1)) r_len[15:8] <= in_data;
      if (w_pack_valid) r_xor <= r_xor ^ in_data;
      if (w_word_valid) begin
        r_idx   <= r_idx + ADDR_W'(1);
        r_addr  <= r_idx;
        r_wdata <= w_word;
      end
      if (w_enter_term) begin
        r_busy <= 1'b0;
      end else if (w_acc) begin
        r_busy <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = r_busy;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed table, reset-mid-load sequence, randomized streams.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int          CAP    = 1 << ADDR_W;

  typedef logic [7:0] byte_q_t[$];

  typedef struct packed {
    logic [127:0] bytes;  // stream byte i lives in bits [8i+7:8i]
    logic [4:0]   len;
    logic [1:0]   gap;    // 0 full rate, 1 every other cycle, 2 random gaps
    logic         exp_done;
    logic         exp_err;
    logic [3:0]   exp_nwr;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  logic [31:0]       exp_words[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check_reset_outputs("rst");
    rst = 1'b0;
    cap_addr.delete();
    cap_data.delete();
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output logic ok);
    ok = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20; t++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("accept", ok, 1);
  endtask

  // Drives a stream and checks each write strobe against the stream's own framing.
  task automatic drive(input byte_q_t s, input int gap_mode);
    int   n;
    int   q;
    int   gap;
    logic ok;
    logic exp_we;
    n = int'({s[1], s[0]});
    for (int p = 0; p < s.size(); p++) begin
      if (gap_mode == 0) gap = 0;
      else if (gap_mode == 1) gap = 1;
      else gap = int'($urandom_range(0, 2));
      send_byte(s[p], gap, ok);
      if (!ok) break;
      q = p - 2;
      exp_we = (n <= CAP) && (q >= 0) && (q < 4 * n) && (q % 4 == 3);
      check("we_pulse", imem_we, exp_we);
      if (exp_we) begin
        check("we_addr", imem_addr, q / 4);
        check("we_data", imem_wdata, {s[p], s[p-1], s[p-2], s[p-3]});
      end
      if (p == 0) check("busy_first", busy, 1);
      if (p < s.size() - 1) check("early_term", done | err, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic model(input byte_q_t s, output logic e_done, output logic e_err);
    int         n;
    logic [7:0] x;
    exp_words.delete();
    n = int'({s[1], s[0]});
    if (n > CAP) begin
      e_done = 1'b0;
      e_err  = 1'b1;
    end else begin
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        exp_words.push_back({s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]});
        for (int j = 0; j < 4; j++) x = x ^ s[2+4*k+j];
      end
      e_done = (s[2+4*n] == x);
      e_err  = !e_done;
    end
  endtask

  task automatic check_final(input string tag, input logic e_done, input logic e_err);
    check({tag, "_done"}, done, e_done);
    check({tag, "_err"}, err, e_err);
    check({tag, "_core_rst_n"}, core_rst_n, e_done);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  vec_t    vecs[6];
  byte_q_t nominal;

  initial begin
    vec_t       v;
    byte_q_t    s;
    logic       ok;
    logic       e_done;
    logic       e_err;
    int         n;
    logic [7:0] x;

    nominal = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h88};

    vecs[0] = '{128'h88_55_66_77_88_11_22_33_44_00_02, 5'd11, 2'd0, 1'b1, 1'b0, 4'd2,
                32'h11223344, 32'h55667788};
    vecs[1] = '{128'h00_00_00, 5'd3, 2'd0, 1'b1, 1'b0, 4'd0, 32'h0, 32'h0};
    vecs[2] = '{128'h00_41, 5'd2, 2'd0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0};
    vecs[3] = '{128'h89_55_66_77_88_11_22_33_44_00_02, 5'd11, 2'd0, 1'b0, 1'b1, 4'd2,
                32'h11223344, 32'h55667788};
    vecs[4] = '{128'h88_55_66_77_88_11_22_33_44_00_02, 5'd11, 2'd1, 1'b1, 1'b0, 4'd2,
                32'h11223344, 32'h55667788};
    vecs[5] = '{128'h22_ef_be_ad_de_00_01, 5'd7, 2'd2, 1'b1, 1'b0, 4'd1,
                32'hefbeadde, 32'h0};

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      s.delete();
      for (int b = 0; b < int'(v.len); b++) s.push_back(v.bytes[8*b +: 8]);
      do_reset();
      drive(s, int'(v.gap));
      check_final($sformatf("vec%0d", i), v.exp_done, v.exp_err);
      check($sformatf("vec%0d_nwr", i), cap_addr.size(), v.exp_nwr);
      if (v.exp_nwr >= 1) begin
        check($sformatf("vec%0d_a0", i), cap_addr.size() > 0 ? 32'(cap_addr[0]) : 'x, 0);
        check($sformatf("vec%0d_w0", i), cap_data.size() > 0 ? cap_data[0] : 'x, v.exp_w0);
      end
      if (v.exp_nwr >= 2) begin
        check($sformatf("vec%0d_a1", i), cap_addr.size() > 1 ? 32'(cap_addr[1]) : 'x, 1);
        check($sformatf("vec%0d_w1", i), cap_data.size() > 1 ? cap_data[1] : 'x, v.exp_w1);
      end
    end

    // Reset in the middle of a load, then a clean reload.
    do_reset();
    for (int p = 0; p < 5; p++) send_byte(nominal[p], 0, ok);
    check("midrst_busy", busy, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check_reset_outputs("midrst");
    rst = 1'b0;
    cap_addr.delete();
    cap_data.delete();
    @(negedge clk);
    check_reset_outputs("midrst_after");
    check("midrst_ready_after", in_ready, 1);
    drive(nominal, 0);
    check_final("reload", 1'b1, 1'b0);
    check("reload_nwr", cap_addr.size(), 2);
    check("reload_w0", cap_data.size() > 0 ? cap_data[0] : 'x, 32'h11223344);
    check("reload_w1", cap_data.size() > 1 ? cap_data[1] : 'x, 32'h55667788);

    // Randomized streams against the reference model, including the capacity boundary.
    for (int it = 0; it < 30; it++) begin
      if (it == 0) n = CAP;
      else if (it == 1) n = CAP + 1;
      else if (it == 2) n = int'($urandom_range(CAP + 2, 65535));
      else n = int'($urandom_range(0, 12));
      s.delete();
      s.push_back(n[7:0]);
      s.push_back(n[15:8]);
      if (n <= CAP) begin
        x = 8'h00;
        for (int b = 0; b < 4 * n; b++) begin
          s.push_back(8'($urandom));
          x = x ^ s[s.size()-1];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      model(s, e_done, e_err);
      do_reset();
      drive(s, 2);
      check_final($sformatf("rnd%0d", it), e_done, e_err);
      check($sformatf("rnd%0d_nwr", it), cap_addr.size(), exp_words.size());
      for (int k = 0; k < exp_words.size(); k++) begin
        if (k < cap_addr.size()) begin
          check($sformatf("rnd%0d_addr%0d", it, k), cap_addr[k], k);
          check($sformatf("rnd%0d_word%0d", it, k), cap_data[k], exp_words[k]);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
